// File: rtl/uart_tx_framer.sv
// UART TX serialiser: start bit, DATA_BITS data (LSB first), optional parity, STOP_BITS stop bits.
// Parity is compiled in only when UART_TX_PARITY_EN is defined; one bit per baud_pulse.
module uart_tx_framer #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_pulse,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_line,
  output logic                 tx_busy,
  output logic                 frame_done
);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_tx_framer: illegal parameter value");
  end

  state_t               state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [3:0]           bit_cnt_q;
  logic [1:0]           stop_cnt_q;
  logic                 tx_line_q;
  logic                 tx_ready_q;
  logic                 tx_busy_q;
  logic                 frame_done_q;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= '0;
      tx_line_q    <= 1'b1;
      tx_ready_q   <= 1'b1;
      tx_busy_q    <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tx_valid && tx_ready_q) begin
            shift_q    <= tx_data;
`ifdef UART_TX_PARITY_EN
            parity_q   <= (^tx_data) ^ 1'(PARITY_ODD);
`endif
            state_q    <= ARM;
            tx_busy_q  <= 1'b1;
            tx_ready_q <= 1'b0;
          end
        end
        // Waiting here for a fresh strobe keeps the start bit a full baud period long.
        ARM: begin
          if (baud_pulse) begin
            tx_line_q <= 1'b0;
            state_q   <= START;
          end
        end
        START: begin
          if (baud_pulse) begin
            tx_line_q <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= 4'd1;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (baud_pulse) begin
            if (bit_cnt_q < 4'(DATA_BITS)) begin
              tx_line_q <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else begin
`ifdef UART_TX_PARITY_EN
              tx_line_q  <= parity_q;
              state_q    <= PARITY;
`else
              tx_line_q  <= 1'b1;
              stop_cnt_q <= 2'd1;
              state_q    <= STOP;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_pulse) begin
            tx_line_q  <= 1'b1;
            stop_cnt_q <= 2'd1;
            state_q    <= STOP;
          end
        end
`endif
        STOP: begin
          tx_line_q <= 1'b1;
          if (baud_pulse) begin
            if (stop_cnt_q < 2'(STOP_BITS)) begin
              stop_cnt_q <= stop_cnt_q + 2'd1;
            end else begin
              state_q      <= IDLE;
              frame_done_q <= 1'b1;
              tx_busy_q    <= 1'b0;
              tx_ready_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          tx_line_q  <= 1'b1;
          tx_ready_q <= 1'b1;
          tx_busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_line    = tx_line_q;
  assign tx_ready   = tx_ready_q;
  assign tx_busy    = tx_busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: 8N1, 8N2 back-to-back, and (with UART_TX_PARITY_EN) even/odd parity.
module tb_uart_tx_framer;

`ifdef UART_TX_PARITY_EN
  localparam int NI = 4;
`else
  localparam int NI = 2;
`endif

  logic       clk;
  logic       rst;
  logic       baud_pulse;
  logic [7:0] tx_data;
  logic       valid [NI];
  logic       ready [NI];
  logic       line  [NI];
  logic       busy  [NI];
  logic       done  [NI];
  int         done_cnt [NI];
  int         checks;
  int         errors;

  uart_tx_framer u_dut_8n1 (
    .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .tx_data(tx_data),
    .tx_valid(valid[0]), .tx_ready(ready[0]), .tx_line(line[0]),
    .tx_busy(busy[0]), .frame_done(done[0])
  );

  uart_tx_framer #(.STOP_BITS(2)) u_dut_8n2 (
    .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .tx_data(tx_data),
    .tx_valid(valid[1]), .tx_ready(ready[1]), .tx_line(line[1]),
    .tx_busy(busy[1]), .frame_done(done[1])
  );

`ifdef UART_TX_PARITY_EN
  uart_tx_framer #(.PARITY_ODD(0)) u_dut_even (
    .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .tx_data(tx_data),
    .tx_valid(valid[2]), .tx_ready(ready[2]), .tx_line(line[2]),
    .tx_busy(busy[2]), .frame_done(done[2])
  );

  uart_tx_framer #(.PARITY_ODD(1)) u_dut_odd (
    .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .tx_data(tx_data),
    .tx_valid(valid[3]), .tx_ready(ready[3]), .tx_line(line[3]),
    .tx_busy(busy[3]), .frame_done(done[3])
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (done[k] === 1'b1) done_cnt[k] <= done_cnt[k] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    baud_pulse = 1'b1;
    tick();
    baud_pulse = 1'b0;
  endtask

  task automatic gap();
    repeat (15) tick();
  endtask

  task automatic accept(input int k, input logic [7:0] d, input string tag);
    tx_data  = d;
    valid[k] = 1'b1;
    tick();
    valid[k] = 1'b0;
    check({tag, "_busy"}, 32'(busy[k]), 32'd1);
    check({tag, "_ready"}, 32'(ready[k]), 32'd0);
    check({tag, "_arm_line"}, 32'(line[k]), 32'd1);
  endtask

  // bits[i] is the line level expected for the i-th baud period after the first strobe.
  task automatic run_frame(input int k, input string tag, input string bits);
    for (int i = 0; i < bits.len(); i++) begin
      pulse();
      check($sformatf("%s_bit%0d", tag, i), 32'(line[k]), (bits[i] == "1") ? 32'd1 : 32'd0);
      if (i == bits.len() - 1) check({tag, "_no_early_done"}, 32'(done[k]), 32'd0);
      gap();
    end
    pulse();
    check({tag, "_done"}, 32'(done[k]), 32'd1);
    check({tag, "_ready_at_done"}, 32'(ready[k]), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy[k]), 32'd0);
    check({tag, "_line_at_done"}, 32'(line[k]), 32'd1);
  endtask

  initial begin
    int snap;
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    baud_pulse = 1'b0;
    tx_data    = 8'h00;
    for (int k = 0; k < NI; k++) begin
      valid[k]    = 1'b0;
      done_cnt[k] = 0;
    end

    tick();
    check("rst_line", 32'(line[0]), 32'd1);
    check("rst_ready", 32'(ready[0]), 32'd1);
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_done", 32'(done[0]), 32'd0);
    rst = 1'b0;

    for (int p = 0; p < 4; p++) begin
      pulse();
      gap();
    end
    check("idle_line", 32'(line[0]), 32'd1);
    check("idle_ready", 32'(ready[0]), 32'd1);
    check("idle_busy", 32'(busy[0]), 32'd0);
    check("idle_done_cnt", 32'(done_cnt[0]), 32'd0);

    // 8N1, 0x55: start, 1,0,1,0,1,0,1,0, stop
    accept(0, 8'h55, "f55");
    repeat (5) tick();
    check("f55_arm_wait_line", 32'(line[0]), 32'd1);
    run_frame(0, "f55", "0101010101");
    tick();
    check("f55_done_one_clk", 32'(done[0]), 32'd0);

    // 0xC3 with tx_data scribbled right after acceptance
    accept(0, 8'hC3, "fc3");
    tx_data = 8'h00;
    tick();
    run_frame(0, "fc3", "0110000111");
    tick();

    // Reset in the middle of a 0xFF frame
    accept(0, 8'hFF, "fff");
    pulse();
    check("fff_start", 32'(line[0]), 32'd0);
    gap();
    pulse();
    check("fff_d0", 32'(line[0]), 32'd1);
    repeat (3) tick();
    snap = done_cnt[0];
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_line", 32'(line[0]), 32'd1);
    check("midrst_busy", 32'(busy[0]), 32'd0);
    check("midrst_ready", 32'(ready[0]), 32'd1);
    check("midrst_done", 32'(done[0]), 32'd0);
    for (int p = 0; p < 12; p++) begin
      pulse();
      gap();
    end
    check("midrst_no_done", 32'(done_cnt[0]), 32'(snap));
    check("midrst_idle_line", 32'(line[0]), 32'd1);

    // 0x3C after the abandoned frame
    accept(0, 8'h3C, "f3c");
    run_frame(0, "f3c", "0001111001");
    tick();

    // 8N2 back-to-back with tx_valid held: 0xA3 then 0x0F
    tx_data  = 8'hA3;
    valid[1] = 1'b1;
    tick();
    check("b2b_first_busy", 32'(busy[1]), 32'd1);
    tx_data = 8'h0F;
    run_frame(1, "fa3", "01100010111");
    tick();
    check("b2b_second_busy", 32'(busy[1]), 32'd1);
    check("b2b_second_ready", 32'(ready[1]), 32'd0);
    check("b2b_second_done_low", 32'(done[1]), 32'd0);
    valid[1] = 1'b0;
    repeat (13) tick();
    check("b2b_arm_line", 32'(line[1]), 32'd1);
    run_frame(1, "f0f", "01111000011");
    tick();
    check("b2b_done_cnt", 32'(done_cnt[1]), 32'd2);
    check("b2b_8n1_untouched", 32'(busy[0]), 32'd0);

`ifdef UART_TX_PARITY_EN
    // 0x80: data 0,0,0,0,0,0,0,1; parity even=1, odd=0
    accept(2, 8'h80, "pev");
    run_frame(2, "pev", "00000000111");
    tick();
    accept(3, 8'h80, "pod");
    run_frame(3, "pod", "00000000101");
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
